// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//
// Round-robin arbiter in front of the shared single-port main memory. One
// client at a time gets a registered one-hot enable and its address, write
// enable and write data are steered onto the RAM. A grant ends on the owning
// client's acknowledge pulse or, if TIMEOUT > 0, when it has lasted TIMEOUT
// cycles; a forced revoke raises a one-cycle timeout_err. RAM read data
// bypasses this block.
//
// Optional build macro: ARB_DEBUG_PORT_EN adds a debug read port
// (dbg_en / dbg_addr) and a DEBUG state that takes the RAM while idle.
//
// Ports
//   CLOCK_50     in   sole clock, rising edge
//   resetIn      in   synchronous reset, active high
//   req          in   [NUM_CLIENTS]  level request per client
//   enable       out  [NUM_CLIENTS]  one-hot registered grant
//   acknowledge  in   [NUM_CLIENTS]  client done, single-cycle pulse
//   cl_addr      in   [NUM_CLIENTS*ADDR_WIDTH] client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   cl_we        in   [NUM_CLIENTS]  client write enables
//   cl_wdata     in   [NUM_CLIENTS*DATA_WIDTH] client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ram_addr     out  [ADDR_WIDTH]   to RAM
//   ram_we       out                 to RAM
//   ram_wdata    out  [DATA_WIDTH]   to RAM
//   busy         out                 a grant (or debug access) is active
//   owner        out  [clog2(NUM_CLIENTS)] current or last granted client
//   timeout_err  out                 pulse in the first IDLE cycle after a revoke
//   dbg_en       in   (ARB_DEBUG_PORT_EN only) debug access request
//   dbg_addr     in   [ADDR_WIDTH] (ARB_DEBUG_PORT_EN only) debug address
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | RAM outputs parked at 0; pick next requester round-robin
//   S_GRANT | client 'owner' drives the RAM until acknowledge or timeout
//   S_DEBUG | debug port reads the RAM (ARB_DEBUG_PORT_EN builds only)

module ram_access_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                              CLOCK_50,
    input  logic                              resetIn,
    input  logic [NUM_CLIENTS-1:0]            req,
    output logic [NUM_CLIENTS-1:0]            enable,
    input  logic [NUM_CLIENTS-1:0]            acknowledge,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_CLIENTS-1:0]            cl_we,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
`ifdef ARB_DEBUG_PORT_EN
    input  logic                              dbg_en,
    input  logic [ADDR_WIDTH-1:0]             dbg_addr,
`endif
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    output logic                              ram_we,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    output logic                              busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]    owner,
    output logic                              timeout_err
);

    localparam int PTR_W = $clog2(NUM_CLIENTS);
    // With TIMEOUT == 0 the counter still exists (one bit) but is never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
`ifdef ARB_DEBUG_PORT_EN
        ,
        S_DEBUG = 2'd2
`endif
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_CLIENTS-1:0] enable_nxt;
    logic [PTR_W-1:0]       owner_nxt;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]       gcnt, gcnt_nxt;
    logic                   timeout_err_nxt;

    logic [PTR_W-1:0]       sel;
    logic                   sel_valid;
    logic [PTR_W-1:0]       cand;
    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic [PTR_W-1:0]       ptr_after_owner;
    logic                   ack_own;
    logic                   timeout_hit;

    // Round-robin pick: walk from the farthest offset down to rr_ptr itself so
    // the requester closest to (at or after) rr_ptr overwrites the others.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_CLIENTS);
            if (req[cand]) begin
                sel       = cand;
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign ptr_after_owner = (owner == PTR_W'(NUM_CLIENTS - 1)) ? '0 : owner + 1'b1;
    assign ack_own         = acknowledge[owner];
    assign timeout_hit     = (TIMEOUT > 0) && (gcnt == CNT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (resetIn) begin
            state       <= S_IDLE;
            enable      <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            gcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            enable      <= enable_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gcnt        <= gcnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        enable_nxt      = enable;
        owner_nxt       = owner;
        rr_ptr_nxt      = rr_ptr;
        gcnt_nxt        = gcnt;
        timeout_err_nxt = 1'b0;

        case (state)
            S_IDLE: begin
`ifdef ARB_DEBUG_PORT_EN
                if (dbg_en) begin
                    state_nxt  = S_DEBUG;
                    enable_nxt = '0;
                end else
`endif
                if (sel_valid) begin
                    state_nxt  = S_GRANT;
                    enable_nxt = sel_onehot;
                    owner_nxt  = sel;
                    gcnt_nxt   = '0;
                end
            end

            S_GRANT: begin
                // Acknowledge wins over a coincident timeout: normal release.
                if (ack_own) begin
                    state_nxt  = S_IDLE;
                    enable_nxt = '0;
                    rr_ptr_nxt = ptr_after_owner;
                end else if (timeout_hit) begin
                    state_nxt       = S_IDLE;
                    enable_nxt      = '0;
                    rr_ptr_nxt      = ptr_after_owner;
                    timeout_err_nxt = 1'b1;
                end else if (gcnt != '1) begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end

`ifdef ARB_DEBUG_PORT_EN
            S_DEBUG: begin
                if (!dbg_en) begin
                    state_nxt = S_IDLE;
                end
            end
`endif

            default: begin
                state_nxt  = S_IDLE;
                enable_nxt = '0;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // RAM steering: the owner's channel while granted, parked at zero otherwise.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state == S_GRANT) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (owner == PTR_W'(i)) begin
                    ram_addr  = cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_we    = cl_we[i];
                    ram_wdata = cl_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
`ifdef ARB_DEBUG_PORT_EN
        else if (state == S_DEBUG) begin
            ram_addr = dbg_addr;
        end
`endif
    end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

- Parametrised arbiter for the shared single-port main memory.
- Replaces the hand-coded per-client state machine with N request/enable/acknowledge channels and a round-robin grant.
- Adds a grant timeout with error reporting.
- Sits between the drawing, write-back and input-modify engines and the `mainMemory` instance.
- Multiplexes one client's address, write-enable and write data onto the RAM at a time.

## Interface

Parameters:
- `NUM_CLIENTS`, 4: number of client channels (2..8).
- `ADDR_WIDTH`, 11: RAM address width.
- `DATA_WIDTH`, 32: RAM data width.
- `TIMEOUT`, 1024: maximum grant length in cycles; 0 disables the timeout.

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `resetIn` in 1: synchronous reset, active-high.
- `req` in NUM_CLIENTS: level request per client.
- `enable` out NUM_CLIENTS: one-hot registered grant, the client's start signal.
- `acknowledge` in NUM_CLIENTS: client finished, single-cycle pulse.
- `cl_addr` in NUM_CLIENTS*ADDR_WIDTH: flattened client addresses; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `cl_we` in NUM_CLIENTS: client write-enables.
- `cl_wdata` in NUM_CLIENTS*DATA_WIDTH: flattened client write data.
- `ram_addr` out ADDR_WIDTH: to RAM.
- `ram_we` out 1: to RAM.
- `ram_wdata` out DATA_WIDTH: to RAM.
- `busy` out 1: a grant is active.
- `owner` out clog2(NUM_CLIENTS): index of the current or last granted client.
- `timeout_err` out 1: one-cycle pulse when a grant is forcibly revoked.

RAM read data is not routed through this block. Clients take `dataRead` directly.

## Operation

State IDLE:
- `enable`=0, `busy`=0.
- `ram_addr`, `ram_we` and `ram_wdata` are all 0.
- If any `req` bit is set, select the first requesting client at or after `rr_ptr`, wrapping modulo NUM_CLIENTS.
- Register `enable`=onehot(sel) and `owner`=sel, then go to GRANT.

State GRANT:
- `busy`=1.
- RAM outputs are driven combinationally from client `owner`'s `cl_addr`, `cl_we` and `cl_wdata`.
- `acknowledge[owner]`=1: go to IDLE, clear `enable`, set `rr_ptr`=(owner+1) mod NUM_CLIENTS.
- Timeout: `gcnt` is cleared on GRANT entry and counts GRANT cycles. If `gcnt`==TIMEOUT-1 with no acknowledge (TIMEOUT>0), go to IDLE, pulse `timeout_err`, and advance `rr_ptr` as above.

Boundary and rule set:
- `acknowledge` from non-owner clients is ignored.
- A `req` drop during GRANT is ignored; only acknowledge or timeout ends a grant.
- Acknowledge and timeout in the same cycle count as a normal release; no `timeout_err`.
- `rr_ptr` wraps from NUM_CLIENTS-1 to 0.
- A sole requester is re-granted after every release.
- `gcnt` is sized clog2(TIMEOUT+1) and never wraps; it saturates at state exit.
- Reset in any state goes to IDLE.

Reset values:
- `enable`=0, `busy`=0, `owner`=0, `timeout_err`=0, `rr_ptr`=0, `gcnt`=0.
- `ram_addr`=0, `ram_we`=0, `ram_wdata`=0.

## Timing

- `req` is sampled in IDLE at edge n. `enable` and `busy` are high after edge n, for the cycle n+1 onward.
- The RAM sees client addresses in the same cycle `enable` is high.
- Read data appears one cycle after the address (RAM latency).
- `acknowledge` sampled at edge m drops `enable` after m; IDLE lasts at least one cycle. The next grant is high after edge m+1, so there is a minimum one-cycle gap with `ram_we`=0.
- Timeout: `enable` is high for exactly TIMEOUT cycles. `timeout_err` is high for the first IDLE cycle.
- `owner` is held through IDLE. On `timeout_err` it indicates the revoked client.

## Configuration

Macro `ARB_DEBUG_PORT_EN`. When defined:
- Adds inputs `dbg_en` (1) and `dbg_addr` (ADDR_WIDTH), plus state DEBUG.
- In IDLE, `dbg_en` has priority over all `req`.
- In DEBUG: `ram_addr`=`dbg_addr`, `ram_we`=0, `busy`=1, `enable`=0.
- DEBUG exits to IDLE the cycle after `dbg_en` falls.
- `dbg_en` never preempts a GRANT.

When not defined, the ports and state are absent and behaviour is as above.

## Test plan

- Reset with `req`=4'b1111 held: `enable`=0 and RAM outputs 0 while `resetIn`=1. After release the grant order is 0,1,2,3,0, each released by a one-cycle `acknowledge`.
- Single client 2: `cl_addr`=11'h123, `cl_we`=1, `cl_wdata`=32'hDEADBEEF. `ram_*` equal these exactly while `enable[2]`=1, and are 0 in the IDLE cycle after acknowledge.
- TIMEOUT=8, client 1 never acknowledges: `enable[1]` is high for exactly 8 cycles, then `timeout_err`=1 for one cycle with `owner`=1. The next grant goes to client 2 if it is requesting.
- Acknowledge on cycle 8 with TIMEOUT=8: normal release, `timeout_err` stays 0. A stray `acknowledge[3]` during client 0's grant has no effect.
- `resetIn` pulsed mid-grant of client 3: next cycle `enable`=0 and `busy`=0. After reset the arbiter restarts from `rr_ptr`=0.
- With `ARB_DEBUG_PORT_EN`: `dbg_en`=1 with `dbg_addr`=11'h7FF while client 0 is granted. `ram_addr` follows client 0 until its acknowledge, then is 11'h7FF with `ram_we`=0 until `dbg_en` falls.
